// File: rtl/decode.sv
// decode -- instruction decode/issue stage sitting directly upstream of execute.
//
// Assembles 1-3 byte instructions from the fetch byte stream, then holds the
// decoded operation on registered outputs while execute_en is high, until
// execute accepts it. Tracks the PC and redirects it on a branch flush.
//
// Byte 0: [7:4] op, [3:2] fmt, [1] reserved (must be 0), [0] src1 MSB.
//   fmt 00: 1 byte, no operands
//   fmt 01: R, 2 bytes  byte1 = {dst[2:0], src0[2:0], src1[1:0]}
//   fmt 10: I, 3 bytes  byte1 as R, byte2 = immediate
//   fmt 11: A, 3 bytes  byte1 = {dst[2:0], reserved, addr[11:8]}, byte2 = addr[7:0]
//
// Optional build macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : a set reserved bit raises illegal_insn for that issue and
//               forces a NOP with all operand fields zero (length from fmt).
//   undefined : illegal_insn is tied to 0, reserved bits are ignored.
//
// Ports:
//   clk, reset_       clock, asynchronous active-low reset
//   fetch_addr        current PC (address of next byte to fetch)
//   i_data/i_valid    instruction byte from fetch; i_ready = decode accepts it
//   flush/tgt_addr    taken branch from execute; redirect PC to tgt_addr
//   execute_en        decoded instruction valid toward execute
//   exec_ready        execute accepts the instruction
//   exec_ctrl         opcode
//   dst_reg           destination register
//   src0_sel/src1_sel register-file read selects
//   imm_data          immediate byte
//   dst_addr          absolute address operand
//   next_addr         PC after the last byte of the most recently assembled instruction
//   illegal_insn      reserved-bit violation flag
module decode #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        reset_,
    output logic [11:0] fetch_addr,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        flush,
    input  logic [11:0] tgt_addr,
    output logic        execute_en,
    input  logic        exec_ready,
    output logic [3:0]  exec_ctrl,
    output logic [2:0]  dst_reg,
    output logic [2:0]  src0_sel,
    output logic [2:0]  src1_sel,
    output logic [7:0]  imm_data,
    output logic [11:0] dst_addr,
    output logic [11:0] next_addr,
    output logic        illegal_insn
);

    typedef enum logic [1:0] {B0, B1, B2, ISSUE} state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [11:0] nxt_q, nxt_d;
    logic [7:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [3:0]  op_q, op_d;
    logic [2:0]  dst_q, dst_d;
    logic [2:0]  src0_q, src0_d;
    logic [2:0]  src1_q, src1_d;
    logic [7:0]  imm_q, imm_d;
    logic [11:0] addr_q, addr_d;
    logic        ill_q, ill_d;

    logic        accept;
    logic        last;
    logic [7:0]  b0, b1;
    logic [1:0]  fmt;
    logic        rsvd_bad;
    logic [3:0]  dec_op;
    logic [2:0]  dec_dst, dec_src0, dec_src1;
    logic [7:0]  dec_imm;
    logic [11:0] dec_addr;
    logic        dec_ill;

    assign i_ready = (state_q != ISSUE) && !flush;
    assign accept  = i_valid && i_ready;

    // Bytes still arriving are taken straight from i_data so the instruction
    // can be decoded in the same cycle its last byte is accepted.
    assign b0  = (state_q == B0) ? i_data : byte0_q;
    assign b1  = (state_q == B1) ? i_data : byte1_q;
    assign fmt = b0[3:2];

    assign last = accept && (((state_q == B0) && (fmt == 2'b00)) ||
                             ((state_q == B1) && (fmt == 2'b01)) ||
                             (state_q == B2));

    assign rsvd_bad = b0[1] || ((fmt == 2'b11) && b1[4]);

    always_comb begin
        dec_op   = b0[7:4];
        dec_dst  = 3'd0;
        dec_src0 = 3'd0;
        dec_src1 = 3'd0;
        dec_imm  = 8'd0;
        dec_addr = 12'd0;
        dec_ill  = 1'b0;
        case (fmt)
            2'b01: begin
                dec_dst  = b1[7:5];
                dec_src0 = b1[4:2];
                dec_src1 = {b0[0], b1[1:0]};
            end
            2'b10: begin
                dec_dst  = b1[7:5];
                dec_src0 = b1[4:2];
                dec_src1 = {b0[0], b1[1:0]};
                dec_imm  = i_data;
            end
            2'b11: begin
                dec_dst  = b1[7:5];
                dec_src0 = b1[7:5];
                dec_addr = {b1[3:0], i_data};
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (rsvd_bad) begin
            dec_op   = 4'h0;
            dec_dst  = 3'd0;
            dec_src0 = 3'd0;
            dec_src1 = 3'd0;
            dec_imm  = 8'd0;
            dec_addr = 12'd0;
            dec_ill  = 1'b1;
        end
`endif
    end

`ifndef DECODE_ILLEGAL_TRAP_EN
    logic rsvd_unused;
    assign rsvd_unused = rsvd_bad;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        nxt_d   = nxt_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        imm_d   = imm_q;
        addr_d  = addr_q;
        ill_d   = ill_q;

        if (flush) begin
            // Drop whatever is partial or pending; no byte is accepted now.
            state_d = B0;
            pc_d    = tgt_addr;
        end else begin
            case (state_q)
                B0: if (accept) begin
                    byte0_d = i_data;
                    state_d = (fmt == 2'b00) ? ISSUE : B1;
                end
                B1: if (accept) begin
                    byte1_d = i_data;
                    state_d = (fmt == 2'b01) ? ISSUE : B2;
                end
                B2: if (accept) state_d = ISSUE;
                ISSUE: if (exec_ready) state_d = B0;
                default: state_d = B0;
            endcase
            if (accept) pc_d = pc_q + 12'd1;
            if (last) begin
                nxt_d  = pc_q + 12'd1;
                op_d   = dec_op;
                dst_d  = dec_dst;
                src0_d = dec_src0;
                src1_d = dec_src1;
                imm_d  = dec_imm;
                addr_d = dec_addr;
                ill_d  = dec_ill;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= B0;
            pc_q    <= RESET_PC;
            nxt_q   <= RESET_PC;
            byte0_q <= 8'd0;
            byte1_q <= 8'd0;
            op_q    <= 4'd0;
            dst_q   <= 3'd0;
            src0_q  <= 3'd0;
            src1_q  <= 3'd0;
            imm_q   <= 8'd0;
            addr_q  <= 12'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            nxt_q   <= nxt_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            imm_q   <= imm_d;
            addr_q  <= addr_d;
            ill_q   <= ill_d;
        end
    end

    assign fetch_addr   = pc_q;
    assign execute_en   = (state_q == ISSUE);
    assign exec_ctrl    = op_q;
    assign dst_reg      = dst_q;
    assign src0_sel     = src0_q;
    assign src1_sel     = src1_q;
    assign imm_data     = imm_q;
    assign dst_addr     = addr_q;
    assign next_addr    = nxt_q;
    assign illegal_insn = ill_q;

endmodule

// File: tb/tb_decode.sv
// Testbench for decode: two instances (RESET_PC = 0x000 and 0xFFF) share one
// stimulus stream and are compared against a byte-queue reference model.
module tb_decode;

    logic        clk;
    logic        reset_;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        flush;
    logic [11:0] tgt_addr;
    logic        exec_ready;

    logic [11:0] fetch_addr_a, dst_addr_a, next_addr_a;
    logic        i_ready_a, execute_en_a, illegal_insn_a;
    logic [3:0]  exec_ctrl_a;
    logic [2:0]  dst_reg_a, src0_sel_a, src1_sel_a;
    logic [7:0]  imm_data_a;

    logic [11:0] fetch_addr_b, dst_addr_b, next_addr_b;
    logic        i_ready_b, execute_en_b, illegal_insn_b;
    logic [3:0]  exec_ctrl_b;
    logic [2:0]  dst_reg_b, src0_sel_b, src1_sel_b;
    logic [7:0]  imm_data_b;

    decode #(.RESET_PC(12'h000)) dut_a (
        .clk(clk), .reset_(reset_), .fetch_addr(fetch_addr_a),
        .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready_a),
        .flush(flush), .tgt_addr(tgt_addr), .execute_en(execute_en_a),
        .exec_ready(exec_ready), .exec_ctrl(exec_ctrl_a), .dst_reg(dst_reg_a),
        .src0_sel(src0_sel_a), .src1_sel(src1_sel_a), .imm_data(imm_data_a),
        .dst_addr(dst_addr_a), .next_addr(next_addr_a), .illegal_insn(illegal_insn_a)
    );

    decode #(.RESET_PC(12'hFFF)) dut_b (
        .clk(clk), .reset_(reset_), .fetch_addr(fetch_addr_b),
        .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready_b),
        .flush(flush), .tgt_addr(tgt_addr), .execute_en(execute_en_b),
        .exec_ready(exec_ready), .exec_ctrl(exec_ctrl_b), .dst_reg(dst_reg_b),
        .src0_sel(src0_sel_b), .src1_sel(src1_sel_b), .imm_data(imm_data_b),
        .dst_addr(dst_addr_b), .next_addr(next_addr_b), .illegal_insn(illegal_insn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nchk;
    int unsigned nfail;

    // Reference model state
    logic [7:0]  mbytes[$];
    bit          issuing;
    logic [11:0] pc_a, pc_b, na_a, na_b;
    logic [3:0]  e_op;
    logic [2:0]  e_dst, e_s0, e_s1;
    logic [7:0]  e_imm;
    logic [11:0] e_addr;
    logic        e_ill;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int insn_len(input int b0);
        int f;
        f = (b0 / 4) % 4;
        return (f == 0) ? 1 : ((f == 1) ? 2 : 3);
    endfunction

    task automatic model_reset();
        mbytes.delete();
        issuing = 1'b0;
        pc_a = 12'h000; pc_b = 12'hFFF;
        na_a = 12'h000; na_b = 12'hFFF;
        e_op = '0; e_dst = '0; e_s0 = '0; e_s1 = '0;
        e_imm = '0; e_addr = '0; e_ill = 1'b0;
    endtask

    task automatic model_decode();
        int b0, b1, b2, f;
        bit bad;
        b0 = int'(mbytes[0]);
        b1 = (mbytes.size() > 1) ? int'(mbytes[1]) : 0;
        b2 = (mbytes.size() > 2) ? int'(mbytes[2]) : 0;
        f  = (b0 / 4) % 4;
        e_op = 4'(b0 / 16);
        e_dst = '0; e_s0 = '0; e_s1 = '0; e_imm = '0; e_addr = '0; e_ill = 1'b0;
        if (f == 1 || f == 2) begin
            e_dst = 3'(b1 / 32);
            e_s0  = 3'((b1 / 4) % 8);
            e_s1  = 3'((b0 % 2) * 4 + (b1 % 4));
            if (f == 2) e_imm = 8'(b2);
        end else if (f == 3) begin
            e_dst  = 3'(b1 / 32);
            e_s0   = e_dst;
            e_addr = 12'((b1 % 16) * 256 + b2);
        end
        bad = ((b0 / 2) % 2 == 1) || (f == 3 && (b1 / 16) % 2 == 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (bad) begin
            e_op = '0; e_dst = '0; e_s0 = '0; e_s1 = '0;
            e_imm = '0; e_addr = '0; e_ill = 1'b1;
        end
`else
        if (bad) e_ill = 1'b0;
`endif
    endtask

    task automatic model_clock(input bit v, input logic [7:0] d, input bit f,
                               input logic [11:0] t, input bit r);
        if (f) begin
            mbytes.delete();
            issuing = 1'b0;
            pc_a = t; pc_b = t;
        end else if (issuing) begin
            if (r) issuing = 1'b0;
        end else if (v) begin
            mbytes.push_back(d);
            pc_a = pc_a + 12'd1;
            pc_b = pc_b + 12'd1;
            if (mbytes.size() == insn_len(int'(mbytes[0]))) begin
                model_decode();
                na_a = pc_a; na_b = pc_b;
                mbytes.delete();
                issuing = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic exp_rdy;
        exp_rdy = !issuing && !flush;
        chk("fetch_addr_a", fetch_addr_a, pc_a);
        chk("fetch_addr_b", fetch_addr_b, pc_b);
        chk("i_ready_a", {11'd0, i_ready_a}, {11'd0, exp_rdy});
        chk("i_ready_b", {11'd0, i_ready_b}, {11'd0, exp_rdy});
        chk("execute_en_a", {11'd0, execute_en_a}, {11'd0, issuing});
        chk("execute_en_b", {11'd0, execute_en_b}, {11'd0, issuing});
        chk("next_addr_a", next_addr_a, na_a);
        chk("next_addr_b", next_addr_b, na_b);
        chk("exec_ctrl", {8'd0, exec_ctrl_a}, {8'd0, e_op});
        chk("dst_reg", {9'd0, dst_reg_a}, {9'd0, e_dst});
        chk("src0_sel", {9'd0, src0_sel_a}, {9'd0, e_s0});
        chk("src1_sel", {9'd0, src1_sel_a}, {9'd0, e_s1});
        chk("imm_data", {4'd0, imm_data_a}, {4'd0, e_imm});
        chk("dst_addr", dst_addr_a, e_addr);
        chk("illegal_insn", {11'd0, illegal_insn_a}, {11'd0, e_ill});
        chk("exec_ctrl_b", {8'd0, exec_ctrl_b}, {8'd0, e_op});
        chk("dst_addr_b", dst_addr_b, e_addr);
    endtask

    // Drive one cycle of inputs shortly after posedge, check at negedge,
    // advance the model, then move to just after the next posedge.
    task automatic step(input bit v, input logic [7:0] d, input bit f,
                        input logic [11:0] t, input bit r);
        i_valid = v; i_data = d; flush = f; tgt_addr = t; exec_ready = r;
        #4;
        check_all();
        model_clock(v, d, f, t, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] start;
        nchk = 0; nfail = 0;
        reset_ = 1'b0; i_valid = 1'b0; i_data = '0; flush = 1'b0;
        tgt_addr = '0; exec_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        reset_ = 1'b1;
        @(posedge clk); #1;

        // R-type 0x34 0xA9; instance b wraps 0xFFF -> 0x000 -> 0x001
        step(1'b1, 8'h34, 1'b0, 12'h0, 1'b1);
        step(1'b1, 8'hA9, 1'b0, 12'h0, 1'b1);
        chk("r_en", {11'd0, execute_en_a}, 12'd1);
        chk("r_ctrl", {8'd0, exec_ctrl_a}, 12'd3);
        chk("r_dst", {9'd0, dst_reg_a}, 12'd5);
        chk("r_src0", {9'd0, src0_sel_a}, 12'd2);
        chk("r_src1", {9'd0, src1_sel_a}, 12'd1);
        chk("r_next_a", next_addr_a, 12'h002);
        chk("wrap_next_b", next_addr_b, 12'h001);
        step(1'b0, 8'h00, 1'b0, 12'h0, 1'b1);

        // I-type with execute stalled for 3 cycles
        step(1'b1, 8'h58, 1'b0, 12'h0, 1'b0);
        step(1'b1, 8'h24, 1'b0, 12'h0, 1'b0);
        step(1'b1, 8'h7F, 1'b0, 12'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 12'h0, 1'b0);
        chk("i_imm", {4'd0, imm_data_a}, 12'h07F);
        chk("i_ctrl", {8'd0, exec_ctrl_a}, 12'd5);
        chk("i_rdy_stall", {11'd0, i_ready_a}, 12'd0);
        step(1'b0, 8'h00, 1'b0, 12'h0, 1'b1);

        // A-type
        start = pc_a;
        step(1'b1, 8'h9C, 1'b0, 12'h0, 1'b1);
        step(1'b1, 8'h6A, 1'b0, 12'h0, 1'b1);
        step(1'b1, 8'hBC, 1'b0, 12'h0, 1'b1);
        chk("a_dst", {9'd0, dst_reg_a}, 12'd3);
        chk("a_src0", {9'd0, src0_sel_a}, 12'd3);
        chk("a_addr", dst_addr_a, 12'hABC);
        chk("a_next", next_addr_a, start + 12'd3);
        step(1'b0, 8'h00, 1'b0, 12'h0, 1'b1);

        // Flush after byte1 of a 3-byte instruction, then 0x12 as a new byte0
        step(1'b1, 8'h58, 1'b0, 12'h0, 1'b1);
        step(1'b1, 8'h24, 1'b0, 12'h0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 12'h123, 1'b1);
        chk("fl_addr", fetch_addr_a, 12'h123);
        chk("fl_en", {11'd0, execute_en_a}, 12'd0);
        step(1'b1, 8'h12, 1'b0, 12'h0, 1'b0);
        chk("rsv_en", {11'd0, execute_en_a}, 12'd1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("rsv_ill", {11'd0, illegal_insn_a}, 12'd1);
        chk("rsv_ctrl", {8'd0, exec_ctrl_a}, 12'd0);
`else
        chk("rsv_ill", {11'd0, illegal_insn_a}, 12'd0);
        chk("rsv_ctrl", {8'd0, exec_ctrl_a}, 12'd1);
`endif
        chk("rsv_next", next_addr_a, 12'h124);
        step(1'b0, 8'h00, 1'b0, 12'h0, 1'b1);

        // Reset asserted mid-instruction
        step(1'b1, 8'h58, 1'b0, 12'h0, 1'b1);
        i_valid = 1'b0;
        reset_ = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        reset_ = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 8'h04, 1'b0, 12'h0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 12'h0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 12'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 19) == 0, 12'($urandom),
                 $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction decode/issue stage directly upstream of execute.
- Accepts a byte stream from fetch and assembles 1-3 byte instructions.
- Drives register-file read selects and presents the decoded operation to execute under a valid/ready handshake.
- Tracks the PC and reloads it on a branch flush from execute.

Parameters:
RESET_PC, 12'h000, PC value loaded on reset.

Ports:
clk  input  1  clock
reset_  input  1  asynchronous active-low reset
fetch_addr  output  12  address of the next byte to fetch (current PC)
i_data  input  8  instruction byte from fetch
i_valid  input  1  i_data valid
i_ready  output  1  decode accepts i_data this cycle
flush  input  1  taken branch from execute; discard and redirect
tgt_addr  input  12  redirect PC, sampled when flush=1
execute_en  output  1  decoded instruction valid toward execute
exec_ready  input  1  execute accepts the instruction
exec_ctrl  output  4  opcode to execute
dst_reg  output  3  destination register
src0_sel  output  3  register-file read select 0
src1_sel  output  3  register-file read select 1
imm_data  output  8  immediate byte
dst_addr  output  12  absolute address operand
next_addr  output  12  address following the issued instruction
illegal_insn  output  1  reserved-bit violation flag

Behaviour:
- Reset (async, reset_=0):
  - state=B0, PC=RESET_PC, next_addr=RESET_PC.
  - execute_en, exec_ctrl, dst_reg, src0_sel, src1_sel, imm_data, dst_addr and illegal_insn are all 0.
- Byte 0 encoding:
  - [7:4] op, driven to exec_ctrl.
  - [3:2] fmt.
  - [1] reserved, must be 0.
  - [0] src1 MSB.
- fmt 00 (1 byte): no operands. dst/src selects and imm are 0.
- fmt 01 R (2 bytes): byte1[7:5]=dst, byte1[4:2]=src0, src1={byte0[0],byte1[1:0]}.
- fmt 10 I (3 bytes): byte1 as R; byte2=imm_data.
- fmt 11 A (3 bytes):
  - byte1[7:5]=dst, and src0_sel=dst.
  - byte1[4] reserved, must be 0.
  - dst_addr={byte1[3:0],byte2}.
- States:
  - B0 -> on byte0 accept: fmt 00 goes to ISSUE, otherwise B1.
  - B1 -> on accept: fmt 01 goes to ISSUE, otherwise B2.
  - B2 -> on accept: ISSUE.
  - ISSUE -> on execute_en && exec_ready: B0.
- Fetch handshake:
  - i_ready = (state != ISSUE) && !flush.
  - A byte is accepted on i_valid && i_ready.
  - PC increments by 1 per accepted byte; 12-bit wrap from 0xFFF to 0x000.
- Issue handshake:
  - execute_en=1 exactly while state=ISSUE.
  - All decoded outputs are registered and held stable throughout ISSUE, including while exec_ready=0.
  - Fields not supplied by the format are 0.
- next_addr is updated when the last byte is accepted and equals the PC after that byte. It holds until the next instruction's last byte.
- fetch_addr = PC at all times.
- Flush:
  - Highest priority, in any state: PC <= tgt_addr, state <= B0, execute_en <= 0 next cycle.
  - The partial or pending instruction is dropped.
  - No byte is accepted in the flush cycle.
  - If flush coincides with the exec_ready accept, the accept still counts for execute; decode simply redirects.
- Back-to-back: the cycle after the ISSUE accept is B0, with i_ready=1. There is no overlap of fetch with issue.
- Reset asserted mid-instruction discards all partial state immediately.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined:
  - A nonzero reserved bit (byte0[1], or byte1[4] in fmt 11) sets illegal_insn=1 for the ISSUE of that instruction.
  - In that case exec_ctrl is forced to 4'h0 (NOP) and dst_reg, src0_sel, src1_sel, imm_data and dst_addr are all 0.
  - Length is still taken from fmt.
- Not defined:
  - illegal_insn is tied to 0.
  - Reserved bits are ignored and the instruction decodes normally.

Test Plan:
- Reset, then stream 0x34, 0xA9 with i_valid=1 and exec_ready=1 -> execute_en pulses 1 cycle after byte1. exec_ctrl=3, dst=5, src0=2, src1=1, next_addr=0x002.
- I-type 0x58, 0x24, 0x7F with exec_ready=0 for 3 cycles -> execute_en and outputs held stable (imm_data=0x7F). i_ready=0 throughout. Accept completes on the first exec_ready=1.
- A-type 0x9C, 0x6A, 0xBC -> dst=3, src0=3, dst_addr=0xABC, next_addr = start+3.
- flush=1 with tgt_addr=0x123 after byte1 of a 3-byte instruction -> no issue, fetch_addr=0x123 next cycle. The following byte is treated as byte0.
- RESET_PC=12'hFFF, 2-byte instruction -> PC wraps to 0x000, then 0x001. next_addr=0x001.
- Byte 0x12 (reserved bit set) with DECODE_ILLEGAL_TRAP_EN -> illegal_insn=1, exec_ctrl=0. Without the macro -> illegal_insn=0, exec_ctrl=1.
